addsub_seq: RTL

//   Parametrised, multi-cycle two's-complement adder/subtractor.

---
 rtl/addsub_seq.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/addsub_seq.sv
// Multi-cycle two's-complement adder/subtractor.
// Processes CHUNK bits per clock, LSB slice first, and ripples the carry between slices.
// Valid/ready handshakes on both sides; signed overflow flag with optional saturation.

module addsub_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CntW-1:0]  LastCnt = CntW'(N - 1);
    localparam logic [WIDTH-1:0] SatPos  = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] SatNeg  = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Operands are shifted right one slice per RUN cycle so the active slice is always at [CHUNK-1:0].
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic             sat_q, sat_d;
    logic             a_msb_q, a_msb_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    // Partial result: each new slice enters at the top and everything shifts down one slice.
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_s;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             slice_ovf;
    logic [WIDTH-1:0] acc_next;

    assign slice_a = a_q[CHUNK-1:0];
    assign slice_b = b_q[CHUNK-1:0];

    // Bit-level ripple across the current slice; also exposes the carry into the slice MSB.
    always_comb begin
        logic rc;
        rc         = c_q;
        slice_s    = '0;
        slice_cmsb = c_q;
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (i == int'(CHUNK) - 1) begin
                slice_cmsb = rc;
            end
            slice_s[i] = slice_a[i] ^ slice_b[i] ^ rc;
            rc         = (slice_a[i] & slice_b[i]) | (slice_a[i] & rc) | (slice_b[i] & rc);
        end
        slice_cout = rc;
    end

    // Only meaningful on the last slice, where the slice MSB is bit WIDTH-1.
    assign slice_ovf = slice_cmsb ^ slice_cout;
    assign acc_next  = WIDTH'({slice_s, acc_q} >> CHUNK);

    // Next-state logic for the control FSM and the datapath registers.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        sat_d   = sat_q;
        a_msb_d = a_msb_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1: invert b here and inject the +1 as carry-in.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{mode}};
                    c_d     = mode;
                    sat_d   = sat;
                    a_msb_d = a[WIDTH-1];
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                c_d   = slice_cout;
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    carry_d = slice_cout;
                    ovf_d   = slice_ovf;
                    // Overflow direction follows the sign of a for both add and subtract.
                    if (sat_q && slice_ovf) begin
                        sum_d = a_msb_q ? SatNeg : SatPos;
                    end else begin
                        sum_d = acc_next;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sat_q   <= 1'b0;
            a_msb_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            sat_q   <= sat_d;
            a_msb_q <= a_msb_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // in_ready is masked by rst so nothing is offered while reset is held.
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule
